// File: rtl/div_arb_ctrl.sv
// Two-requester round-robin front end for an iterative divider: grants one request,
// clears and runs the divider, and returns the quotient or a timeout error.
// Optional macro DIV_ZERO_CHK_EN answers a zero divisor directly without running the divider.
module div_arb_ctrl #(
    parameter int C_NUM_BITS   = 4,
    parameter int C_MAX_CYCLES = 16
) (
    input  logic                  CK,
    input  logic                  RN,
    input  logic                  REQ0,
    input  logic                  REQ1,
    input  logic [C_NUM_BITS-1:0] A0,
    input  logic [C_NUM_BITS-1:0] B0,
    input  logic [C_NUM_BITS-1:0] A1,
    input  logic [C_NUM_BITS-1:0] B1,
    output logic                  GNT0,
    output logic                  GNT1,
    output logic                  DONE0,
    output logic                  DONE1,
    output logic [C_NUM_BITS-1:0] Q,
    output logic                  ERR,
    output logic                  DIV_E,
    output logic                  DIV_RN,
    output logic [C_NUM_BITS-1:0] DIV_A,
    output logic [C_NUM_BITS-1:0] DIV_B,
    input  logic [C_NUM_BITS-1:0] DIV_Q,
    input  logic                  DIV_VALID
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESP} state_t;

    localparam logic [7:0] MAX_CNT = 8'(C_MAX_CYCLES);

    state_t                state_q;
    logic                  prio_q;
    logic                  owner_q;
    logic [7:0]            cnt_q;
    logic [7:0]            cnt_d;
    logic [C_NUM_BITS-1:0] q_q;
    logic [C_NUM_BITS-1:0] a_q;
    logic [C_NUM_BITS-1:0] b_q;
    logic                  err_q;
    logic                  done0_q;
    logic                  done1_q;
    logic                  div_e_q;
    logic                  div_rn_q;

    logic                  any_req;
    logic                  win;
    logic [C_NUM_BITS-1:0] win_a;
    logic [C_NUM_BITS-1:0] win_b;

    // win = 1 selects requester 1; prio_q breaks ties in favour of the one not served last
    always_comb begin
        any_req = REQ0 | REQ1;
        win     = (REQ0 & REQ1) ? prio_q : REQ1;
        win_a   = win ? A1 : A0;
        win_b   = win ? B1 : B0;
        cnt_d   = cnt_q + 8'd1;
    end

    // Grant is decided in the IDLE cycle itself so operands are taken on that same edge
    assign GNT0 = RN & (state_q == S_IDLE) & any_req & ~win;
    assign GNT1 = RN & (state_q == S_IDLE) & any_req &  win;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q  <= S_IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            cnt_q    <= 8'd0;
            q_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            err_q    <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            div_e_q  <= 1'b0;
            div_rn_q <= 1'b0;
        end else begin
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            div_rn_q <= 1'b1;
            div_e_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        a_q     <= win_a;
                        b_q     <= win_b;
                        owner_q <= win;
                        prio_q  <= ~win;
`ifdef DIV_ZERO_CHK_EN
                        if (win_b == '0) begin
                            state_q <= S_RESP;
                            q_q     <= '1;
                            err_q   <= 1'b1;
                            done0_q <= ~win;
                            done1_q <= win;
                        end else begin
                            state_q  <= S_LOAD;
                            div_rn_q <= 1'b0;
                            div_e_q  <= 1'b1;
                        end
`else
                        state_q  <= S_LOAD;
                        div_rn_q <= 1'b0;
                        div_e_q  <= 1'b1;
`endif
                    end
                end
                S_LOAD: begin
                    state_q <= S_RUN;
                    div_e_q <= 1'b1;
                    cnt_q   <= 8'd0;
                end
                S_RUN: begin
                    cnt_q <= cnt_d;
                    if (DIV_VALID) begin
                        state_q <= S_RESP;
                        q_q     <= DIV_Q;
                        err_q   <= 1'b0;
                        done0_q <= ~owner_q;
                        done1_q <= owner_q;
                    end else if (cnt_d == MAX_CNT) begin
                        state_q <= S_RESP;
                        q_q     <= '1;
                        err_q   <= 1'b1;
                        done0_q <= ~owner_q;
                        done1_q <= owner_q;
                    end else begin
                        div_e_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign DONE0  = done0_q;
    assign DONE1  = done1_q;
    assign Q      = q_q;
    assign ERR    = err_q;
    assign DIV_E  = div_e_q;
    assign DIV_RN = div_rn_q;
    assign DIV_A  = a_q;
    assign DIV_B  = b_q;

endmodule

// File: tb/tb_div_arb_ctrl.sv
// Directed testbench for div_arb_ctrl with a small behavioural divider model.
module tb_div_arb_ctrl;

    logic       CK;
    logic       RN;
    logic       REQ0, REQ1;
    logic [3:0] A0, B0, A1, B1;
    logic       GNT0, GNT1, DONE0, DONE1, ERR;
    logic [3:0] Q;
    logic       DIV_E, DIV_RN;
    logic [3:0] DIV_A, DIV_B;
    logic [3:0] DIV_Q;
    logic       DIV_VALID;

    int total = 0;
    int bad   = 0;

    // divider model: raises DIV_VALID on RUN cycle number vat (0 = never)
    int vat  = 0;
    int mrun = 0;
    assign DIV_VALID = (vat != 0) && DIV_E && DIV_RN && (mrun + 1 == vat);

    always @(posedge CK) begin
        if (!DIV_RN) mrun <= 0;
        else if (DIV_E) mrun <= mrun + 1;
    end

    int dual_cnt = 0;
    int g1_cnt   = 0;
    int d1_cnt   = 0;
    int done_cnt = 0;
    always @(negedge CK) begin
        if (GNT0 && GNT1) dual_cnt <= dual_cnt + 1;
        if (DONE0 && DONE1) dual_cnt <= dual_cnt + 1;
        if (GNT1) g1_cnt <= g1_cnt + 1;
        if (DONE1) d1_cnt <= d1_cnt + 1;
        if (DONE0 || DONE1) done_cnt <= done_cnt + 1;
    end

    div_arb_ctrl #(.C_NUM_BITS(4), .C_MAX_CYCLES(16)) dut (
        .CK(CK), .RN(RN), .REQ0(REQ0), .REQ1(REQ1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
        .Q(Q), .ERR(ERR), .DIV_E(DIV_E), .DIV_RN(DIV_RN),
        .DIV_A(DIV_A), .DIV_B(DIV_B), .DIV_Q(DIV_Q), .DIV_VALID(DIV_VALID)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Waits for a DONE pulse; rc counts RUN cycles seen before it, n is the DONE cycle index.
    task automatic wait_done(input int budget, output int rc, output int n, output bit found);
        rc = 0; n = 0; found = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge CK);
            if (DONE0 || DONE1) begin
                n = i; found = 1'b1;
                break;
            end
            if (DIV_E && DIV_RN) rc++;
        end
    endtask

    task automatic test_reset();
        RN = 1'b0; REQ0 = 1'b1; REQ1 = 1'b0;
        A0 = 4'h3; B0 = 4'h1; A1 = 4'h0; B1 = 4'h0; DIV_Q = 4'h0; vat = 0;
        repeat (2) @(negedge CK);
        total++; if (GNT0 !== 1'b0) begin bad++; $display("FAIL rst_gnt0 got=%b exp=0", GNT0); end
        total++; if (GNT1 !== 1'b0) begin bad++; $display("FAIL rst_gnt1 got=%b exp=0", GNT1); end
        total++; if ({DONE0, DONE1} !== 2'b00) begin bad++; $display("FAIL rst_done got=%b exp=00", {DONE0, DONE1}); end
        total++; if (Q !== 4'h0) begin bad++; $display("FAIL rst_q got=%h exp=0", Q); end
        total++; if (ERR !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", ERR); end
        total++; if (DIV_E !== 1'b0) begin bad++; $display("FAIL rst_div_e got=%b exp=0", DIV_E); end
        total++; if (DIV_RN !== 1'b0) begin bad++; $display("FAIL rst_div_rn got=%b exp=0", DIV_RN); end
        total++; if ({DIV_A, DIV_B} !== 8'h00) begin bad++; $display("FAIL rst_div_ab got=%h exp=00", {DIV_A, DIV_B}); end
        REQ0 = 1'b0;
        @(posedge CK); #1; RN = 1'b1;
        @(negedge CK);
        total++; if (DIV_RN !== 1'b0) begin bad++; $display("FAIL rel_div_rn_before_edge got=%b exp=0", DIV_RN); end
        @(negedge CK);
        total++; if (DIV_RN !== 1'b1) begin bad++; $display("FAIL rel_div_rn_after_edge got=%b exp=1", DIV_RN); end
        total++; if (DIV_E !== 1'b0) begin bad++; $display("FAIL rel_div_e got=%b exp=0", DIV_E); end
    endtask

    task automatic test_timeout();
        int rc, n; bit found;
        @(posedge CK); #1; vat = 0; REQ1 = 1'b1; A1 = 4'h5; B1 = 4'h3;
        @(negedge CK);
        total++; if ({GNT0, GNT1} !== 2'b01) begin bad++; $display("FAIL to_gnt got=%b exp=01", {GNT0, GNT1}); end
        @(posedge CK); #1; REQ1 = 1'b0;
        @(negedge CK);
        total++; if ({DIV_RN, DIV_E} !== 2'b01) begin bad++; $display("FAIL to_load rn_e got=%b exp=01", {DIV_RN, DIV_E}); end
        total++; if ({DIV_A, DIV_B} !== 8'h53) begin bad++; $display("FAIL to_operands got=%h exp=53", {DIV_A, DIV_B}); end
        wait_done(60, rc, n, found);
        total++; if (!found) begin bad++; $display("FAIL to_done_seen got=none exp=pulse"); end
        total++; if (rc !== 16) begin bad++; $display("FAIL to_run_cycles got=%0d exp=16", rc); end
        total++; if (n !== 17) begin bad++; $display("FAIL to_done_cycle got=%0d exp=17", n); end
        total++; if ({DONE0, DONE1} !== 2'b01) begin bad++; $display("FAIL to_done_who got=%b exp=01", {DONE0, DONE1}); end
        total++; if (Q !== 4'hF) begin bad++; $display("FAIL to_q got=%h exp=f", Q); end
        total++; if (ERR !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", ERR); end
        total++; if (DIV_E !== 1'b0) begin bad++; $display("FAIL to_resp_div_e got=%b exp=0", DIV_E); end
    endtask

    task automatic test_basic();
        int rc, n; bit found;
        @(posedge CK); #1; vat = 4; DIV_Q = 4'h4; REQ0 = 1'b1; A0 = 4'h9; B0 = 4'h2;
        @(negedge CK);
        total++; if ({GNT0, GNT1} !== 2'b10) begin bad++; $display("FAIL basic_gnt got=%b exp=10", {GNT0, GNT1}); end
        @(posedge CK); #1; REQ0 = 1'b0; A0 = 4'h0; B0 = 4'h0;
        @(negedge CK);
        total++; if ({DIV_RN, DIV_E} !== 2'b01) begin bad++; $display("FAIL basic_load rn_e got=%b exp=01", {DIV_RN, DIV_E}); end
        total++; if ({DIV_A, DIV_B} !== 8'h92) begin bad++; $display("FAIL basic_operands got=%h exp=92", {DIV_A, DIV_B}); end
        total++; if (GNT0 !== 1'b0) begin bad++; $display("FAIL basic_gnt_pulse got=%b exp=0", GNT0); end
        wait_done(40, rc, n, found);
        total++; if (!found) begin bad++; $display("FAIL basic_done_seen got=none exp=pulse"); end
        total++; if (rc !== 4) begin bad++; $display("FAIL basic_run_cycles got=%0d exp=4", rc); end
        total++; if ({DONE0, DONE1} !== 2'b10) begin bad++; $display("FAIL basic_done_who got=%b exp=10", {DONE0, DONE1}); end
        total++; if (Q !== 4'h4) begin bad++; $display("FAIL basic_q got=%h exp=4", Q); end
        total++; if (ERR !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", ERR); end
        @(negedge CK);
        total++; if (DONE0 !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", DONE0); end
        total++; if ({Q, ERR} !== 5'b01000) begin bad++; $display("FAIL basic_hold q_err got=%b exp=01000", {Q, ERR}); end
        total++; if ({DIV_A, DIV_B} !== 8'h92) begin bad++; $display("FAIL basic_hold_ab got=%h exp=92", {DIV_A, DIV_B}); end
    endtask

    task automatic test_round_robin();
        int rc, n, wt, g; bit found;
        RN = 1'b0; REQ0 = 1'b1; REQ1 = 1'b1; vat = 1; DIV_Q = 4'h3;
        A0 = 4'h6; B0 = 4'h2; A1 = 4'h8; B1 = 4'h4;
        @(negedge CK);
        total++; if ({GNT0, GNT1} !== 2'b00) begin bad++; $display("FAIL rr_rst_gnt got=%b exp=00", {GNT0, GNT1}); end
        @(posedge CK); #1; RN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wt = 0; g = -1;
            for (int i = 1; i <= 20; i++) begin
                @(negedge CK);
                if (GNT0 || GNT1) begin wt = i; g = GNT1 ? 1 : 0; break; end
            end
            total++; if (g !== k % 2) begin bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, g, k % 2); end
            total++; if (wt !== 1) begin bad++; $display("FAIL rr_gap[%0d] got=%0d exp=1", k, wt); end
            wait_done(20, rc, n, found);
            total++; if (n !== 3) begin bad++; $display("FAIL rr_latency[%0d] got=%0d exp=3", k, n); end
            total++; if ({DONE0, DONE1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_done_who[%0d] got=%b", k, {DONE0, DONE1}); end
        end
        @(posedge CK); #1; REQ0 = 1'b0; REQ1 = 1'b0;
        total++; if (Q !== 4'h3) begin bad++; $display("FAIL rr_q got=%h exp=3", Q); end
        total++; if (dual_cnt !== 0) begin bad++; $display("FAIL rr_double got=%0d exp=0", dual_cnt); end
    endtask

    task automatic test_abort();
        int rc, n, d_before; bit found;
        @(posedge CK); #1; vat = 0; REQ0 = 1'b1; A0 = 4'h8; B0 = 4'h2;
        @(negedge CK);
        total++; if (GNT0 !== 1'b1) begin bad++; $display("FAIL ab_gnt0 got=%b exp=1", GNT0); end
        @(posedge CK); #1; REQ0 = 1'b0;
        repeat (3) @(negedge CK);
        total++; if ({DIV_RN, DIV_E} !== 2'b11) begin bad++; $display("FAIL ab_running got=%b exp=11", {DIV_RN, DIV_E}); end
        RN = 1'b0;
        #1;
        total++; if ({DIV_RN, DIV_E} !== 2'b00) begin bad++; $display("FAIL ab_div_ctl got=%b exp=00", {DIV_RN, DIV_E}); end
        total++; if ({Q, ERR} !== 5'b00000) begin bad++; $display("FAIL ab_q_err got=%b exp=00000", {Q, ERR}); end
        total++; if ({DIV_A, DIV_B} !== 8'h00) begin bad++; $display("FAIL ab_div_ab got=%h exp=00", {DIV_A, DIV_B}); end
        total++; if ({GNT0, GNT1, DONE0, DONE1} !== 4'b0000) begin bad++; $display("FAIL ab_pulses got=%b exp=0000", {GNT0, GNT1, DONE0, DONE1}); end
        @(posedge CK); #1; RN = 1'b1;
        d_before = done_cnt;
        repeat (20) @(negedge CK);
        total++; if (done_cnt !== d_before) begin bad++; $display("FAIL ab_no_done got=%0d exp=%0d", done_cnt, d_before); end
        @(posedge CK); #1; vat = 2; DIV_Q = 4'h2; REQ1 = 1'b1; A1 = 4'h6; B1 = 4'h3;
        @(negedge CK);
        total++; if (GNT1 !== 1'b1) begin bad++; $display("FAIL ab_next_gnt1 got=%b exp=1", GNT1); end
        @(posedge CK); #1; REQ1 = 1'b0;
        wait_done(40, rc, n, found);
        total++; if (rc !== 2) begin bad++; $display("FAIL ab_next_run got=%0d exp=2", rc); end
        total++; if ({DONE1, Q, ERR} !== 6'b1_0010_0) begin bad++; $display("FAIL ab_next_result got=%b exp=100100", {DONE1, Q, ERR}); end
    endtask

    task automatic test_div_zero();
        int rc, n; bit found; logic de_seen;
        @(posedge CK); #1; vat = 3; DIV_Q = 4'h9; REQ1 = 1'b1; A1 = 4'h7; B1 = 4'h0;
        @(negedge CK);
        total++; if (GNT1 !== 1'b1) begin bad++; $display("FAIL dz_gnt1 got=%b exp=1", GNT1); end
        @(posedge CK); #1; REQ1 = 1'b0;
`ifdef DIV_ZERO_CHK_EN
        de_seen = 1'b0;
        @(negedge CK);
        de_seen = de_seen | DIV_E;
        total++; if ({DONE0, DONE1} !== 2'b01) begin bad++; $display("FAIL dz_done1 got=%b exp=01", {DONE0, DONE1}); end
        total++; if ({Q, ERR} !== 5'b11111) begin bad++; $display("FAIL dz_q_err got=%b exp=11111", {Q, ERR}); end
        for (int i = 0; i < 5; i++) begin
            @(negedge CK);
            de_seen = de_seen | DIV_E;
        end
        total++; if (de_seen !== 1'b0) begin bad++; $display("FAIL dz_div_e got=%b exp=0", de_seen); end
        total++; if (DONE1 !== 1'b0) begin bad++; $display("FAIL dz_done_pulse got=%b exp=0", DONE1); end
`else
        de_seen = 1'b0;
        @(negedge CK);
        total++; if ({DIV_RN, DIV_E} !== 2'b01) begin bad++; $display("FAIL dz_load got=%b exp=01", {DIV_RN, DIV_E}); end
        total++; if ({DIV_A, DIV_B} !== 8'h70) begin bad++; $display("FAIL dz_operands got=%h exp=70", {DIV_A, DIV_B}); end
        wait_done(40, rc, n, found);
        total++; if (rc !== 3 || n !== 4) begin bad++; $display("FAIL dz_run got=%0d/%0d exp=3/4", rc, n); end
        total++; if ({DONE1, Q, ERR} !== 6'b1_1001_0) begin bad++; $display("FAIL dz_result got=%b exp=110010", {DONE1, Q, ERR}); end
        total++; if (de_seen !== 1'b0) begin bad++; $display("FAIL dz_scratch got=%b exp=0", de_seen); end
`endif
    endtask

    task automatic test_withdraw();
        int rc, n, g1b, d1b; bit found;
        @(posedge CK); #1; vat = 5; DIV_Q = 4'h1; REQ0 = 1'b1; REQ1 = 1'b0; A0 = 4'h5; B0 = 4'h5;
        @(negedge CK);
        total++; if (GNT0 !== 1'b1) begin bad++; $display("FAIL wd_gnt0 got=%b exp=1", GNT0); end
        g1b = g1_cnt; d1b = d1_cnt;
        @(posedge CK); #1; REQ0 = 1'b0; REQ1 = 1'b1; A1 = 4'h3; B1 = 4'h1;
        @(posedge CK); #1;
        @(posedge CK); #1; REQ1 = 1'b0;
        wait_done(40, rc, n, found);
        total++; if ({DONE0, DONE1, Q} !== 6'b10_0001) begin bad++; $display("FAIL wd_done0 got=%b exp=100001", {DONE0, DONE1, Q}); end
        repeat (10) @(negedge CK);
        total++; if (g1_cnt !== g1b) begin bad++; $display("FAIL wd_no_gnt1 got=%0d exp=%0d", g1_cnt, g1b); end
        total++; if (d1_cnt !== d1b) begin bad++; $display("FAIL wd_no_done1 got=%0d exp=%0d", d1_cnt, d1b); end
        total++; if (dual_cnt !== 0) begin bad++; $display("FAIL wd_double got=%0d exp=0", dual_cnt); end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_basic();
        test_round_robin();
        test_abort();
        test_div_zero();
        test_withdraw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_arb_ctrl.md
DIV_ARB_CTRL -- requirements
Module: div_arb_ctrl

Interface
REQ-001 SHALL have parameter C_NUM_BITS, default 4, operand/result width.
REQ-002 SHALL have parameter C_MAX_CYCLES, default 16, run-cycle timeout limit (2..255).
REQ-003 SHALL have ports: CK  in  1  clock; RN  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: REQ0, REQ1  in  1  requester 0/1 request level.
REQ-005 SHALL have ports: A0, B0, A1, B1  in  C_NUM_BITS  dividend/divisor per requester.
REQ-006 SHALL have ports: GNT0, GNT1  out  1  one-cycle operand-accept pulse.
REQ-007 SHALL have ports: DONE0, DONE1  out  1  one-cycle result pulse; Q  out  C_NUM_BITS  quotient; ERR  out  1  error flag.
REQ-008 SHALL have ports: DIV_E  out  1  divider clock enable; DIV_RN  out  1  divider clear, active-low; DIV_A, DIV_B  out  C_NUM_BITS  divider operands; DIV_Q  in  C_NUM_BITS  divider result; DIV_VALID  in  1  divider result valid.

Function
REQ-009 SHALL implement FSM states IDLE, LOAD, RUN, RESP.
REQ-010 IDLE: if any REQx high, SHALL pulse GNTx for the winner, register its A/B into DIV_A/DIV_B, and go to LOAD next cycle; otherwise stay in IDLE.
REQ-011 Arbitration SHALL be round-robin: on simultaneous REQ0/REQ1, grant the requester not granted last; pointer updates only on grant; after reset, requester 0 wins.
REQ-012 LOAD: SHALL drive DIV_RN=0, DIV_E=1 for exactly one cycle, then go to RUN.
REQ-013 RUN: SHALL drive DIV_RN=1, DIV_E=1, increment an 8-bit run counter cleared on entry; on DIV_VALID=1, capture DIV_Q into Q, clear ERR, go to RESP.
REQ-014 RUN: if the counter reaches C_MAX_CYCLES with DIV_VALID=0, SHALL set Q to all ones, set ERR=1, and go to RESP (timeout).
REQ-015 RESP: SHALL pulse DONEx for the granted requester for one cycle with Q/ERR valid, DIV_E=0, and return to IDLE.
REQ-016 Q and ERR SHALL hold their values until the next RESP; DIV_A/DIV_B SHALL hold until the next grant.
REQ-017 DIV_E SHALL be 0 in IDLE and RESP; DIV_RN SHALL be 1 outside LOAD.
REQ-018 Requester handshake: operands SHALL be sampled only in the GNT cycle; REQx deasserting before grant withdraws the request with no side effect.
REQ-019 A REQx held high through DONEx SHALL be treated as a new request in the following IDLE cycle and is subject to round-robin.
REQ-020 GNT0/GNT1 SHALL never be high together; DONE0/DONE1 SHALL never be high together.
REQ-021 Minimum latency, GNT to DONE, SHALL be 3 cycles (LOAD, one RUN cycle with DIV_VALID high, RESP).

Reset
REQ-022 RN low SHALL asynchronously force state IDLE, GNTx=0, DONEx=0, Q=0, ERR=0, DIV_E=0, DIV_RN=0, DIV_A=0, DIV_B=0, run counter 0, and round-robin pointer to favour requester 0.
REQ-023 RN low mid-operation SHALL abort the operation with no DONE pulse; after release, DIV_RN SHALL return to 1 on the first clock edge.

Configuration
REQ-024 Macro DIV_ZERO_CHK_EN: when defined, a granted request with B==0 SHALL skip LOAD/RUN and go IDLE->RESP with Q all ones and ERR=1, with DIV_E held 0, giving 1-cycle GNT-to-DONE latency.
REQ-025 Without DIV_ZERO_CHK_EN, B==0 SHALL be sequenced normally; the result is whatever the divider returns, or a timeout.

Verification
REQ-026 Reset, then REQ0=1 with A0=9, B0=2; divider model asserts DIV_VALID on the 4th RUN cycle with DIV_Q=4 -> GNT0, one LOAD cycle with DIV_RN=0, DONE0 with Q=4 and ERR=0.
REQ-027 REQ0 and REQ1 both held high from reset -> grant order 0,1,0,1; there is never a double grant.
REQ-028 Divider model never asserts DIV_VALID, C_MAX_CYCLES=16 -> DONE after exactly 16 RUN cycles, with Q=4'hF and ERR=1.
REQ-029 RN pulsed low during RUN -> all outputs return to reset values immediately; no DONE pulse; the next request is served normally.
REQ-030 A1=7, B1=0: with DIV_ZERO_CHK_EN, DONE1 occurs the cycle after GNT1 with Q=4'hF, ERR=1, and DIV_E never high; without the macro, LOAD/RUN occur.
REQ-031 REQ1 drops before grant while REQ0 is busy -> no GNT1 and no DONE1 are issued.
